// File: rtl/line_memory_responder.sv
// line_memory_responder
//
// Front-end for the cache's line-wide backing memory. One request is accepted
// at a time. The responder waits LATENCY cycles to model main-memory latency,
// then drives one port of an external dual-port line RAM for a single cycle.
// The RAM has a registered read, so read data is captured one cycle later.
// The completed transaction is then returned on the response channel.
//
// Ports
//   clk, reset            single clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write line, 0 = read line
//   req_addr, req_data    line address and write data
//   resp_valid/ready      response handshake
//   resp_write            echo of the transaction type (1 = write ack)
//   resp_data             read data; all zeros for write acks
//   mem_addr, mem_data_in address and write data to the RAM port
//   mem_we                RAM write enable, high only in the ACCESS cycle
//   mem_data_out          RAM read data, valid the cycle after the address
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting down the modelled memory latency
// ACCESS | RAM port access; write enable asserted for writes
// READ   | RAM read data arrives and is captured
// RESP   | response held until the requester accepts it

module line_memory_responder #(
  parameter int N             = 32,
  parameter int WORDSPERLINE  = 2,
  parameter int ADDRESS_WIDTH = 10,
  parameter int LATENCY       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDRESS_WIDTH-1:0]            req_addr,
  input  logic [WORDSPERLINE-1:0][N-1:0]      req_data,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic                                resp_write,
  output logic [WORDSPERLINE-1:0][N-1:0]      resp_data,
  output logic [ADDRESS_WIDTH-1:0]            mem_addr,
  output logic [WORDSPERLINE-1:0][N-1:0]      mem_data_in,
  output logic                                mem_we,
  input  logic [WORDSPERLINE-1:0][N-1:0]      mem_data_out
);

  // The counter must hold LATENCY itself, and it is never narrower than one bit.
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_READ,
    S_RESP
  } state_t;

  typedef logic [WORDSPERLINE-1:0][N-1:0] line_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  line_t                    data_q, data_d;
  logic                     write_q, write_d;
  logic                     req_ready_q, req_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_write_q, resp_write_d;
  line_t                    resp_data_q, resp_data_d;
  logic                     mem_we_q, mem_we_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_d      = write_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_data_d  = resp_data_q;
    mem_we_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          data_d      = req_data;
          write_d     = req_write;
          req_ready_d = 1'b0;
          // With no latency to model, go straight to the RAM access.
          if (LATENCY == 0) begin
            state_d  = S_ACCESS;
            mem_we_d = req_write;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // Leaving on a count of 1 makes WAIT last exactly LATENCY cycles.
        // A count of 0 cannot occur here; it is treated the same way so the
        // FSM can never stall in WAIT.
        if (cnt_q <= CNT_ONE) begin
          cnt_d    = '0;
          state_d  = S_ACCESS;
          mem_we_d = write_q;
        end
      end

      S_ACCESS: begin
        if (write_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_write_d = 1'b1;
          resp_data_d  = '0;
        end else begin
          state_d = S_READ;
        end
      end

      S_READ: begin
        // The RAM has sampled the address at the end of ACCESS, so its
        // output is valid during this cycle.
        resp_data_d  = mem_data_out;
        resp_write_d = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // The async reset also clears mem_we, so a write caught by reset is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_data_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_q      <= write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_data_q  <= resp_data_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_write  = resp_write_q;
  assign resp_data   = resp_data_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = data_q;
  assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;

  typedef logic [1:0][31:0] line_t;
  typedef struct {
    logic       wr;
    logic [9:0] addr;
    line_t      data;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int sel;  // 0 selects the LATENCY=4 instance, 1 the LATENCY=0 instance

  logic       req_valid, req_write, resp_ready;
  logic [9:0] req_addr;
  line_t      req_data;
  line_t      ram_dout;

  logic       req_valid_a, req_ready_a, resp_valid_a, resp_write_a, mem_we_a;
  line_t      resp_data_a, mem_data_in_a;
  logic [9:0] mem_addr_a;
  logic       req_valid_b, req_ready_b, resp_valid_b, resp_write_b, mem_we_b;
  line_t      resp_data_b, mem_data_in_b;
  logic [9:0] mem_addr_b;

  assign req_valid_a = req_valid && (sel == 0);
  assign req_valid_b = req_valid && (sel == 1);

  line_memory_responder #(.N(32), .WORDSPERLINE(2), .ADDRESS_WIDTH(10), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_write(resp_write_a),
    .resp_data(resp_data_a),
    .mem_addr(mem_addr_a), .mem_data_in(mem_data_in_a), .mem_we(mem_we_a),
    .mem_data_out(ram_dout)
  );

  line_memory_responder #(.N(32), .WORDSPERLINE(2), .ADDRESS_WIDTH(10), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_write(resp_write_b),
    .resp_data(resp_data_b),
    .mem_addr(mem_addr_b), .mem_data_in(mem_data_in_b), .mem_we(mem_we_b),
    .mem_data_out(ram_dout)
  );

  // Selected instance view
  logic       m_req_valid, m_req_ready, m_resp_valid, m_resp_write, m_we;
  line_t      m_resp_data, m_din;
  logic [9:0] m_addr;
  always_comb begin
    m_req_valid  = sel ? req_valid_b  : req_valid_a;
    m_req_ready  = sel ? req_ready_b  : req_ready_a;
    m_resp_valid = sel ? resp_valid_b : resp_valid_a;
    m_resp_write = sel ? resp_write_b : resp_write_a;
    m_resp_data  = sel ? resp_data_b  : resp_data_a;
    m_we         = sel ? mem_we_b     : mem_we_a;
    m_din        = sel ? mem_data_in_b : mem_data_in_a;
    m_addr       = sel ? mem_addr_b   : mem_addr_a;
  end

  // Line RAM: registered read, write on mem_we
  line_t ram [1024];
  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_din;
    ram_dout <= ram[m_addr];
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  // Scoreboard state
  exp_t  exp_q[$];
  int    acc_q[$];
  line_t model [1024];
  int    cyc = 0;
  int    acc_cnt = 0;
  int    we_cnt = 0;
  bit    in_resp = 0;
  bit    chk_rdy = 0;
  exp_t  cur;
  line_t cur_rdata;
  int    cur_acc;

  // Request-handshake recorder: cyc holds the index of the latest edge.
  always @(posedge clk) begin
    cyc++;
    if (!reset && m_req_valid && m_req_ready) begin
      acc_q.push_back(cyc);
      acc_cnt++;
    end
  end

  // Response monitor. In cycle n after the acceptance edge, cyc - acc == n-1.
  always @(negedge clk) begin
    if (reset) begin
      in_resp = 0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("req_ready_after_resp_hs", m_req_ready, 1);
        chk_rdy = 0;
      end
      if (m_we) begin
        we_cnt++;
        if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("mem_we_spurious");
        else if (!exp_q[0].wr) fail_now("mem_we_on_read");
        else begin
          chk("mem_we_cycle", cyc - acc_q[0], exp_q[0].lat);
          chk("mem_addr", m_addr, exp_q[0].addr);
          chk("mem_data_in", m_din, exp_q[0].data);
        end
      end
      if (m_resp_valid) begin
        if (!in_resp) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("resp_spurious");
          else begin
            cur       = exp_q.pop_front();
            cur_acc   = acc_q.pop_front();
            cur_rdata = cur.wr ? '0 : cur.data;
            in_resp   = 1;
            chk("resp_latency", cyc - cur_acc, cur.lat + (cur.wr ? 1 : 2));
            chk("resp_write", m_resp_write, cur.wr);
            chk("resp_data", m_resp_data, cur_rdata);
          end
        end else begin
          chk("resp_write_stable", m_resp_write, cur.wr);
          chk("resp_data_stable", m_resp_data, cur_rdata);
        end
        chk("req_ready_low_in_resp", m_req_ready, 0);
        if (resp_ready && in_resp) begin
          in_resp = 0;
          chk_rdy = 1;
        end
      end else if (in_resp) begin
        fail_now("resp_valid_dropped");
        in_resp = 0;
      end
    end
  end

  task automatic send(input logic wr, input logic [9:0] a, input line_t d, input bit keep);
    exp_t e;
    int   start;
    bit   ok;
    start  = acc_cnt;
    ok     = 0;
    e.wr   = wr;
    e.addr = a;
    e.data = wr ? d : model[a];
    e.lat  = (sel == 0) ? 4 : 0;
    exp_q.push_back(e);
    if (wr) model[a] = d;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("req_accept_timeout");
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !in_resp && m_req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"},   m_req_ready, 1);
    chk({tag, "_resp_valid"},  m_resp_valid, 0);
    chk({tag, "_resp_write"},  m_resp_write, 0);
    chk({tag, "_resp_data"},   m_resp_data, 0);
    chk({tag, "_mem_we"},      m_we, 0);
    chk({tag, "_mem_addr"},    m_addr, 0);
    chk({tag, "_mem_data_in"}, m_din, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    line_t saved;
    int    w0;
    int    a0;
    reset      = 1'b1;
    sel        = 0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = '0;
      model[i] = '0;
    end
    #1;
    chk_reset_values("rst_l4");
    sel = 1;
    #1;
    chk_reset_values("rst_l0");
    sel = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Write then read back, LATENCY=4
    send(1'b1, 10'h005, {32'hDEADBEEF, 32'h12345678}, 0);
    wait_idle();
    send(1'b0, 10'h005, '0, 0);
    wait_idle();

    // Read response stalled for 5 cycles while another request waits
    resp_ready = 1'b0;
    send(1'b0, 10'h005, '0, 1);
    a0 = acc_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_resp_valid) break;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("no_accept_during_stall", acc_cnt, a0);
    resp_ready = 1'b1;
    send(1'b1, 10'h006, {32'h0BADF00D, 32'h600DCAFE}, 0);
    wait_idle();

    // LATENCY=0 instance, top address
    sel = 1;
    send(1'b1, 10'h3FF, {32'h00000001, 32'h00000002}, 0);
    wait_idle();
    send(1'b0, 10'h3FF, '0, 0);
    wait_idle();

    // Reset in cycle 2 of a write; the write must not happen
    sel   = 0;
    saved = model[10'h010];
    w0    = we_cnt;
    send(1'b1, 10'h010, {32'hAAAAAAAA, 32'h55555555}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_values("midrst");
    exp_q.delete();
    acc_q.delete();
    model[10'h010] = saved;
    // Request already pending as reset releases
    begin
      exp_t e;
      e.wr   = 1'b0;
      e.addr = 10'h010;
      e.data = model[10'h010];
      e.lat  = 4;
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 10'h010;
    req_data  = '0;
    a0 = acc_cnt;
    repeat (2) @(posedge clk);
    #1;
    chk("no_accept_in_reset", acc_cnt, a0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("accept_first_edge_after_release", acc_cnt - a0, 1);
    req_valid = 1'b0;
    wait_idle();
    chk("no_mem_we_after_reset", we_cnt, w0);

    // Three requests with req_valid held high throughout
    send(1'b1, 10'h020, {32'hCAFEF00D, 32'h0BADBEEF}, 1);
    send(1'b0, 10'h020, '0, 1);
    send(1'b0, 10'h3FF, '0, 0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
